fp16_addsub_arbiter: RTL
========================

# fp16_addsub_arbiter

Round-robin scheduler that shares one fully pipelined FP16 add/sub unit (five stages, fixed latency, no stall) between NUM_REQ requesters. It accepts at most one operation per cycle and drives the unit's operand inputs. A tag shift register tracks each issued operation so its result returns to the requester that issued it. It sits between the FP16 add/sub pipeline and the compute lanes that issue scalar adds and subtracts.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- LATENCY, 5: cycles from pipe_arg_* valid to pipe_ret_0 valid; must match the attached unit.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  16*NUM_REQ  operand X, FP16 {s,e[4:0],f[9:0]}, slice i for requester i.
- req_b  in  16*NUM_REQ  operand Y, same packing.
- req_sub  in  NUM_REQ  1 = X−Y, 0 = X+Y.
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid&ready.
- drain  in  1  blocks new grants while high.
- idle  out  1  no operation in flight and no output pending.
- pipe_arg_0  out  16  operand X to unit.
- pipe_arg_1  out  16  operand Y to unit.
- pipe_arg_2  out  1  is_sub to unit.
- pipe_ret_0  in  16  unit result.
- res_valid  out  NUM_REQ  one-hot result strobe; no backpressure, requester must take it.
- res_data  out  16  result, valid when any res_valid bit is set.
- inflight  out  $clog2(LATENCY+3)  operations accepted and not yet returned.

## Operation
- Arbitration is combinational. req_ready = the first requester with req_valid set, searching from rr_ptr upward with wrap. req_ready is all zero when drain=1.
- On an accepted handshake, {a,b,sub} of the winner is registered into pipe_arg_*. The tag {valid=1, id} enters stage 0 of a LATENCY+1 deep tag shift register. If there is no accept, a bubble (valid=0) enters and pipe_arg_* hold their value.
- rr_ptr is set to (granted id + 1) mod NUM_REQ on accept and holds otherwise.
- At the tag output, res_valid[id] = tag.valid and res_data = pipe_ret_0.
- inflight is incremented on accept and decremented on return. If both happen in one cycle it is unchanged. It never exceeds LATENCY+1 (or LATENCY+2 with the output register).
- idle = (inflight == 0).
- drain does not affect operations already in flight. They complete normally.
- Only the unit handles the FP16 arithmetic, including zero, sign and normalization. The controller never alters the data.
- Reset during operation clears all tags, rr_ptr and inflight. The pipeline results of in-flight operations are then discarded with no res_valid, and requesters must re-issue.

## Timing
- Reset values: req_ready follows the combinational rule with rr_ptr=0. res_valid=0, res_data=0, pipe_arg_*=0, inflight=0, idle=1.
- Handshake at edge T puts operands on pipe_arg_* from T+1. The result is strobed in the cycle after edge T+1+LATENCY, which is 6 cycles after accept by default.
- Throughput is one operation per cycle.
- A requester that holds valid through several grants is served at most once every NUM_REQ cycles while the others are also requesting. With no other requesters it is served every cycle.
- Back-to-back results are delivered in issue order, one per cycle.

## Configuration
- FP16_ARB_OUTREG_EN defined: res_valid and res_data are registered, adding 1 cycle (7 by default). The reset value of both is 0.
- FP16_ARB_OUTREG_EN undefined: res_valid and res_data are combinational from the tag and pipe_ret_0.

## Structure
- Shared package fp16_arb_pkg holds:
  - FP16_W=16;
  - the fp16_t packed struct {sign, exp[4:0], frac[9:0]};
  - the tag_t struct {valid, id};
  - constant FP16_ONE=16'h3C00.
- One sub-module, fp16_rr_picker: combinational round-robin one-hot picker taking valid and ptr.
- The tag shift register and counters live in the top level.

## Test plan
- Single request from requester 0: 0x3C00+0x3C00, sub=0 → res_valid[0] 6 cycles after accept, res_data 0x4000, inflight 1→0, idle returns to 1.
- All four requesters assert at once:
  - operations 1+2, 2+1, 2−1, 1−2, encoded as 0x3C00/0x4000 pairs;
  - grants go in order 0,1,2,3 on consecutive cycles;
  - results are 0x4200, 0x4200, 0x3C00, 0xBC00 on consecutive cycles with the matching one-hot strobes.
- Fairness with only requesters 1 and 3 continuously valid: grants alternate 1,3,1,3 and rr_ptr wraps correctly.
- drain is raised while 3 operations are in flight: no new grants, the 3 results still return, and idle rises 1 cycle after the last return.
- rst is asserted asynchronously mid-stream with 4 operations in flight: all outputs return to reset values immediately, and no res_valid fires afterwards for those operations.
- With FP16_ARB_OUTREG_EN: repeat the single-request scenario and check the result arrives at 7 cycles with data 0x4000.

Source files
------------

// File: rtl/fp16_arb_pkg.sv
// Shared types and constants for the FP16 add/sub arbiter.
//   FP16_W   : width of an FP16 word
//   ID_W     : width of a requester id in a tag (covers up to 8 requesters)
//   fp16_t   : {sign, exp[4:0], frac[9:0]}
//   tag_t    : {valid, id} travelling alongside an operation in the unit
//   FP16_ONE : encoding of +1.0
package fp16_arb_pkg;

  localparam int FP16_W = 16;
  localparam int ID_W   = 3;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  localparam logic [FP16_W-1:0] FP16_ONE = 16'h3C00;

endpackage

// File: rtl/fp16_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   valid    in  NUM_REQ  request vector
//   ptr      in  PTR_W    highest-priority index for this cycle
//   grant    out NUM_REQ  one-hot grant (first valid at or after ptr, with wrap)
//   grant_id out PTR_W    index of the granted requester
//   any      out 1        some requester was granted
module fp16_rr_picker
  import fp16_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_id,
  output logic               any
);

  int idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = PTR_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_addsub_arbiter.sv
// Round-robin scheduler sharing one fixed-latency FP16 add/sub pipeline
// between NUM_REQ requesters. A tag shift register follows each issued
// operation so the result is strobed back to the requester that issued it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_a/req_b/req_sub  per-requester operation requests
//   req_ready                one-hot grant (zero while drain is high)
//   drain                    blocks new grants; in-flight work completes
//   idle                     nothing in flight, no output pending
//   pipe_arg_0/1/2           operand X, operand Y, is_sub to the unit
//   pipe_ret_0               unit result
//   res_valid/res_data       one-hot result strobe and result data
//   inflight                 operations accepted and not yet returned
//
// Build option: define FP16_ARB_OUTREG_EN to register res_valid/res_data
// (one extra cycle of latency); otherwise they are combinational.
module fp16_addsub_arbiter
  import fp16_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int LATENCY = 5,
  localparam int PTR_W   = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(LATENCY + 3)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [16*NUM_REQ-1:0]     req_a,
  input  logic [16*NUM_REQ-1:0]     req_b,
  input  logic [NUM_REQ-1:0]        req_sub,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      drain,
  output logic                      idle,
  output logic [15:0]               pipe_arg_0,
  output logic [15:0]               pipe_arg_1,
  output logic                      pipe_arg_2,
  input  logic [15:0]               pipe_ret_0,
  output logic [NUM_REQ-1:0]        res_valid,
  output logic [15:0]               res_data,
  output logic [CNT_W-1:0]          inflight
);

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_id;
  logic               grant_any;
  logic               accept;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  fp16_t              arg_a_q, arg_a_d;
  fp16_t              arg_b_q, arg_b_d;
  logic               arg_sub_q, arg_sub_d;
  tag_t               tag_in_d;
  tag_t               tag_q [LATENCY+1];
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  tag_t               ret_tag;
  logic [NUM_REQ-1:0] ret_onehot;
  logic [15:0]        ret_data;
  logic               ret_event;

  fp16_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .valid    (req_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  // Grants only go to valid requesters, so any grant is a handshake.
  assign req_ready = drain ? '0 : grant;
  assign accept    = grant_any & ~drain;

  always_comb begin
    arg_a_d   = arg_a_q;
    arg_b_d   = arg_b_q;
    arg_sub_d = arg_sub_q;
    rr_ptr_d  = rr_ptr_q;
    tag_in_d  = '0;
    if (accept) begin
      arg_a_d   = req_a[int'(grant_id)*FP16_W +: FP16_W];
      arg_b_d   = req_b[int'(grant_id)*FP16_W +: FP16_W];
      arg_sub_d = req_sub[grant_id];
      tag_in_d  = '{valid: 1'b1, id: ID_W'(grant_id)};
      rr_ptr_d  = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + PTR_W'(1);
    end
  end

  // Stage LATENCY of the tag line lines up with pipe_ret_0: the tag enters
  // stage 0 on the same edge the operands are registered into pipe_arg_*.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      arg_a_q   <= '0;
      arg_b_q   <= '0;
      arg_sub_q <= 1'b0;
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      arg_a_q   <= arg_a_d;
      arg_b_q   <= arg_b_d;
      arg_sub_q <= arg_sub_d;
      tag_q[0]  <= tag_in_d;
      for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign pipe_arg_0 = arg_a_q;
  assign pipe_arg_1 = arg_b_q;
  assign pipe_arg_2 = arg_sub_q;

  assign ret_tag    = tag_q[LATENCY];
  assign ret_onehot = ret_tag.valid ? (NUM_REQ'(1) << ret_tag.id) : '0;
  // Data is passed through untouched; gating keeps the bus at zero when
  // nothing is returning (and right after reset).
  assign ret_data   = ret_tag.valid ? pipe_ret_0 : '0;

`ifdef FP16_ARB_OUTREG_EN
  logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
  logic [15:0]        res_data_q, res_data_d;

  always_comb begin
    res_valid_d = ret_onehot;
    res_data_d  = ret_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  // An operation counts as in flight until it leaves the output register.
  assign ret_event = |res_valid_q;
`else
  assign res_valid = ret_onehot;
  assign res_data  = ret_data;
  assign ret_event = ret_tag.valid;
`endif

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, ret_event})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= '0;
    else     inflight_q <= inflight_d;
  end

  assign inflight = inflight_q;
  assign idle     = (inflight_q == '0);

endmodule
